// File: rtl/mapa_write_arbiter.sv
// Arbitrates the single mapa write port among snake update, fruit spawner and obstacle placer.
// Define MAPA_ARB_RR_EN for round-robin arbitration; otherwise fixed priority 0 > 1 > 2.
module mapa_write_arbiter #(
   parameter int unsigned COORD_BITS  = 10,
   parameter int unsigned CELL_BITS   = 2,
   parameter int unsigned MAPA_WIDTH  = 40,
   parameter int unsigned MAPA_HEIGHT = 30
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  hold,
   input  logic [2:0]            req,
   input  logic [COORD_BITS-1:0] req_x0,
   input  logic [COORD_BITS-1:0] req_y0,
   input  logic [CELL_BITS-1:0]  req_d0,
   input  logic [COORD_BITS-1:0] req_x1,
   input  logic [COORD_BITS-1:0] req_y1,
   input  logic [CELL_BITS-1:0]  req_d1,
   input  logic [COORD_BITS-1:0] req_x2,
   input  logic [COORD_BITS-1:0] req_y2,
   input  logic [CELL_BITS-1:0]  req_d2,
   output logic [2:0]            ack,
   output logic                  wenable,
   output logic [COORD_BITS-1:0] wx,
   output logic [COORD_BITS-1:0] wy,
   output logic [CELL_BITS-1:0]  wdata,
   output logic                  oob_err,
   output logic [15:0]           wr_count
);

   localparam int unsigned NUM_REQ = 3;

   logic [2:0]            elig;
   logic [2:0]            grant;
   logic [1:0]            win;
   logic [1:0]            cand;
   logic                  any_grant;
   logic                  in_range;
   logic [COORD_BITS-1:0] sel_x;
   logic [COORD_BITS-1:0] sel_y;
   logic [CELL_BITS-1:0]  sel_d;

`ifdef MAPA_ARB_RR_EN
   logic [1:0] rr_ptr;
`endif

   // Registered ack masks a requester for the cycle it spends dropping req.
   always_comb begin
      elig      = req & ~ack & {3{~hold}};
      grant     = '0;
      win       = '0;
      cand      = '0;
      any_grant = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef MAPA_ARB_RR_EN
         cand = 2'((32'(rr_ptr) + k) % NUM_REQ);
`else
         cand = 2'(k);
`endif
         if (!any_grant && elig[cand]) begin
            grant[cand] = 1'b1;
            win         = cand;
            any_grant   = 1'b1;
         end
      end
   end

   // Winner payload and map bounds check.
   always_comb begin
      sel_x = req_x0;
      sel_y = req_y0;
      sel_d = req_d0;
      case (win)
         2'd1: begin
            sel_x = req_x1;
            sel_y = req_y1;
            sel_d = req_d1;
         end
         2'd2: begin
            sel_x = req_x2;
            sel_y = req_y2;
            sel_d = req_d2;
         end
         default: ;
      endcase
      in_range = (sel_x < COORD_BITS'(MAPA_WIDTH)) && (sel_y < COORD_BITS'(MAPA_HEIGHT));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ack      <= '0;
         wenable  <= 1'b0;
         wx       <= '0;
         wy       <= '0;
         wdata    <= '0;
         oob_err  <= 1'b0;
         wr_count <= '0;
      end else begin
         ack     <= grant;
         wenable <= 1'b0;
         if (any_grant) begin
            if (in_range) begin
               wenable <= 1'b1;
               wx      <= sel_x;
               wy      <= sel_y;
               wdata   <= sel_d;
               if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            end else begin
               oob_err <= 1'b1;
            end
         end
      end
   end

`ifdef MAPA_ARB_RR_EN
   // Pointer moves past the winner on every grant, dropped writes included.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rr_ptr <= '0;
      end else if (any_grant) begin
         rr_ptr <= (win == 2'd2) ? 2'd0 : win + 2'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mapa_write_arbiter.sv
// Directed-vector bench for mapa_write_arbiter; expectations follow MAPA_ARB_RR_EN.
module tb_mapa_write_arbiter;

   logic       clk;
   logic       reset;
   logic       hold;
   logic [2:0] req;
   logic [9:0] req_x0, req_y0, req_x1, req_y1, req_x2, req_y2;
   logic [1:0] req_d0, req_d1, req_d2;
   logic [2:0] ack;
   logic       wenable;
   logic [9:0] wx, wy;
   logic [1:0] wdata;
   logic       oob_err;
   logic [15:0] wr_count;

   int n_vec;
   int n_miss;

   mapa_write_arbiter dut (
      .clk(clk), .reset(reset), .hold(hold), .req(req),
      .req_x0(req_x0), .req_y0(req_y0), .req_d0(req_d0),
      .req_x1(req_x1), .req_y1(req_y1), .req_d1(req_d1),
      .req_x2(req_x2), .req_y2(req_y2), .req_d2(req_d2),
      .ack(ack), .wenable(wenable), .wx(wx), .wy(wy), .wdata(wdata),
      .oob_err(oob_err), .wr_count(wr_count)
   );

   always #5 clk = ~clk;

`ifdef MAPA_ARB_RR_EN
   // pointer is 2 after the single write to requester 1
   logic [2:0] exp_contend [3] = '{3'b100, 3'b001, 3'b010};
   logic [9:0] exp_cx      [3] = '{10'd3, 10'd1, 10'd2};
   logic [2:0] exp_hold    [2] = '{3'b010, 3'b001};
   logic [2:0] exp_fair    [5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
`else
   logic [2:0] exp_contend [3] = '{3'b001, 3'b010, 3'b100};
   logic [9:0] exp_cx      [3] = '{10'd1, 10'd2, 10'd3};
   logic [2:0] exp_hold    [2] = '{3'b001, 3'b010};
   logic [2:0] exp_fair    [5] = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001};
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      n_vec  = 0;
      n_miss = 0;
      clk    = 1'b0;
      reset  = 1'b0;
      hold   = 1'b0;
      req    = 3'b111;
      req_x0 = 10'd1; req_y0 = 10'd1; req_d0 = 2'd1;
      req_x1 = 10'd2; req_y1 = 10'd2; req_d1 = 2'd2;
      req_x2 = 10'd3; req_y2 = 10'd3; req_d2 = 2'd3;

      // reset with all requests pending
      repeat (3) tick();
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_wen", 32'(wenable), 32'd0);
      chk("rst_cnt", 32'(wr_count), 32'd0);
      chk("rst_oob", 32'(oob_err), 32'd0);
      chk("rst_wx", 32'(wx), 32'd0);
      reset = 1'b1;
      req   = 3'b000;
      tick();

      // single write from requester 1
      req_x1 = 10'd5; req_y1 = 10'd7; req_d1 = 2'b10;
      req    = 3'b010;
      tick();
      chk("single_ack", 32'(ack), 32'b010);
      chk("single_wen", 32'(wenable), 32'd1);
      chk("single_wx", 32'(wx), 32'd5);
      chk("single_wy", 32'(wy), 32'd7);
      chk("single_wd", 32'(wdata), 32'd2);
      req = 3'b000;
      tick();
      chk("single_ack_off", 32'(ack), 32'd0);
      chk("single_wen_off", 32'(wenable), 32'd0);
      chk("single_cnt", 32'(wr_count), 32'd1);
      chk("single_wx_hold", 32'(wx), 32'd5);

      // three-way contention, each requester drops after its ack
      req_x1 = 10'd2; req_y1 = 10'd2; req_d1 = 2'd2;
      req = 3'b111;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("contend_ack%0d", i), 32'(ack), 32'(exp_contend[i]));
         chk($sformatf("contend_wx%0d", i), 32'(wx), 32'(exp_cx[i]));
         req = req & ~ack;
      end
      tick();
      chk("contend_idle", 32'(ack), 32'd0);
      chk("contend_cnt", 32'(wr_count), 32'd4);

      // x at MAPA_WIDTH is dropped
      req_x2 = 10'd40; req_y2 = 10'd0; req_d2 = 2'd1;
      req = 3'b100;
      tick();
      chk("oobx_ack", 32'(ack), 32'b100);
      chk("oobx_wen", 32'(wenable), 32'd0);
      chk("oobx_flag", 32'(oob_err), 32'd1);
      req = 3'b000;
      tick();
      chk("oobx_cnt", 32'(wr_count), 32'd4);
      chk("oobx_sticky", 32'(oob_err), 32'd1);

      // y at MAPA_HEIGHT is dropped
      req_x0 = 10'd0; req_y0 = 10'd30;
      req = 3'b001;
      tick();
      chk("ooby_ack", 32'(ack), 32'b001);
      chk("ooby_wen", 32'(wenable), 32'd0);
      req = 3'b000;
      tick();
      chk("ooby_cnt", 32'(wr_count), 32'd4);

      // last legal cell still commits
      req_x2 = 10'd39; req_y2 = 10'd29; req_d2 = 2'd3;
      req = 3'b100;
      tick();
      chk("edge_ack", 32'(ack), 32'b100);
      chk("edge_wen", 32'(wenable), 32'd1);
      chk("edge_wx", 32'(wx), 32'd39);
      chk("edge_wy", 32'(wy), 32'd29);
      req = 3'b000;
      tick();
      chk("edge_cnt", 32'(wr_count), 32'd5);
      chk("edge_oob", 32'(oob_err), 32'd1);

      // hold blocks grants; request waits
      req_x0 = 10'd10; req_y0 = 10'd11; req_d0 = 2'd1;
      hold = 1'b1;
      req  = 3'b001;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("hold_ack%0d", i), 32'(ack), 32'd0);
         chk($sformatf("hold_wen%0d", i), 32'(wenable), 32'd0);
      end
      hold = 1'b0;
      tick();
      chk("unhold_ack", 32'(ack), 32'b001);
      chk("unhold_wen", 32'(wenable), 32'd1);
      chk("unhold_wx", 32'(wx), 32'd10);
      req = 3'b000;
      tick();
      chk("unhold_cnt", 32'(wr_count), 32'd6);

      // hold rising right after a grant: that grant completes, the other waits
      req_x0 = 10'd1; req_y0 = 10'd1;
      req = 3'b011;
      tick();
      chk("hmid_first", 32'(ack), 32'(exp_hold[0]));
      chk("hmid_first_wen", 32'(wenable), 32'd1);
      req  = req & ~ack;
      hold = 1'b1;
      tick();
      chk("hmid_wait0", 32'(ack), 32'd0);
      tick();
      chk("hmid_wait1", 32'(ack), 32'd0);
      hold = 1'b0;
      tick();
      chk("hmid_second", 32'(ack), 32'(exp_hold[1]));
      req = 3'b000;
      tick();
      chk("hmid_cnt", 32'(wr_count), 32'd8);

      // reset in the grant cycle discards the grant
      req   = 3'b001;
      reset = 1'b0;
      tick();
      chk("rmid_ack", 32'(ack), 32'd0);
      chk("rmid_wen", 32'(wenable), 32'd0);
      chk("rmid_cnt", 32'(wr_count), 32'd0);
      chk("rmid_oob", 32'(oob_err), 32'd0);
      req = 3'b000;
      tick();
      reset = 1'b1;
      tick();

      // 0 and 1 never drop req; 2 drops after its ack
      req = 3'b111;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("fair_ack%0d", i), 32'(ack), 32'(exp_fair[i]));
         if (ack[2]) req[2] = 1'b0;
      end
      req = 3'b000;
      tick();
      chk("fair_idle", 32'(ack), 32'd0);
      chk("fair_cnt", 32'(wr_count), 32'd5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
